// File: rtl/flag_status_reg_if.sv
// Bus bundle for the condition-flag register: ALU/control inputs and flag/stack status outputs.
// The master drives the update controls and the slave (the flag register) returns the status.
interface flag_status_reg_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] flag_in;
    logic [WIDTH-1:0] flag_we;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] flags_out;
    logic [CW-1:0]    stack_cnt;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output flag_in, flag_we, set_mask, clr_mask, push, pop, err_clr,
        input  flags_out, stack_cnt, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  flag_in, flag_we, set_mask, clr_mask, push, pop, err_clr,
        output flags_out, stack_cnt, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/flag_status_reg.sv
// Condition-flag register with per-bit write mask, force set/clear and a LIFO save/restore
// stack for interrupt/call context; sticky overflow/underflow error flags.
module flag_status_reg #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic               clk,
    input logic               rst_n,
    flag_status_reg_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full_s, empty_s;
    logic             push_ok_s, pop_ok_s;
    logic             ovf_evt_s, unf_evt_s;
    logic [AW-1:0]    wr_idx_s, rd_idx_s;
    logic [WIDTH-1:0] normal_s;

    // Per-bit update with priority clear > set > masked write > hold.
    function automatic logic [WIDTH-1:0] flag_update(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic [WIDTH-1:0] we,
        input logic [WIDTH-1:0] set,
        input logic [WIDTH-1:0] clr
    );
        logic [WIDTH-1:0] v;
        v = (cur & ~we) | (din & we);
        v = v | set;
        return v & ~clr;
    endfunction

    // Stack qualification, error events and next-state selection.
    always_comb begin
        full_s    = (cnt_q == CW'(DEPTH));
        empty_s   = (cnt_q == {CW{1'b0}});
        push_ok_s = bus.push & ~bus.pop & ~full_s;
        pop_ok_s  = bus.pop & ~bus.push & ~empty_s;
        ovf_evt_s = bus.push & ~bus.pop & full_s;
        unf_evt_s = bus.pop & ~bus.push & empty_s;
        wr_idx_s  = cnt_q[AW-1:0];
        rd_idx_s  = AW'(cnt_q - CW'(1));
        normal_s  = flag_update(flags_q, bus.flag_in, bus.flag_we, bus.set_mask, bus.clr_mask);

        flags_d = normal_s;
        cnt_d   = cnt_q;
        if (pop_ok_s) begin
            flags_d = stack_q[rd_idx_s];
            cnt_d   = cnt_q - CW'(1);
        end else if (push_ok_s) begin
            cnt_d   = cnt_q + CW'(1);
        end else begin
            cnt_d   = cnt_q;
        end

        // A fresh error event outranks err_clr so nothing is lost.
        ovf_d = ovf_evt_s | (ovf_q & ~bus.err_clr);
        unf_d = unf_evt_s | (unf_q & ~bus.err_clr);
    end

    // Flag, counter and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= RESET_VAL;
            cnt_q   <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage saves the pre-update flags; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            stack_q[wr_idx_s] <= flags_q;
        end
    end

    assign bus.flags_out   = flags_q;
    assign bus.stack_cnt   = cnt_q;
    assign bus.stack_full  = full_s;
    assign bus.stack_empty = empty_s;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_flag_status_reg.sv
// Directed bench for flag_status_reg: hand-computed expectations for reset, masked writes,
// priority, push/pop, overflow/underflow and err_clr behaviour.
module tb_flag_status_reg;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    flag_status_reg_if #(.WIDTH(4), .DEPTH(4)) bus ();

    flag_status_reg #(.WIDTH(4), .DEPTH(4), .RESET_VAL(4'b0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] din, input logic [3:0] we, input logic [3:0] set,
                       input logic [3:0] clr, input logic ps, input logic pp, input logic ec);
        bus.flag_in  = din;
        bus.flag_we  = we;
        bus.set_mask = set;
        bus.clr_mask = clr;
        bus.push     = ps;
        bus.pop      = pp;
        bus.err_clr  = ec;
        @(posedge clk);
        #1;
        bus.flag_we  = 4'b0000;
        bus.set_mask = 4'b0000;
        bus.clr_mask = 4'b0000;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] f, input int cnt,
                             input logic ovf, input logic unf);
        chk({tag, "_flags"}, bus.flags_out, f);
        chk({tag, "_cnt"},   bus.stack_cnt, cnt);
        chk({tag, "_full"},  bus.stack_full, (cnt == 4) ? 1 : 0);
        chk({tag, "_empty"}, bus.stack_empty, (cnt == 0) ? 1 : 0);
        chk({tag, "_ovf"},   bus.ovf_err, ovf);
        chk({tag, "_unf"},   bus.unf_err, unf);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.flag_in = 4'b0000; bus.flag_we = 4'b0000; bus.set_mask = 4'b0000;
        bus.clr_mask = 4'b0000; bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state("reset", 4'b0000, 0, 1'b0, 1'b0);

        // Build dirty state, then assert reset mid-cycle
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk_state("pop_empty", 4'b0000, 0, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk_state("pre_rst", 4'b1111, 1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 4'b0000, 0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Masked write
        cyc(4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("masked_write", bus.flags_out, 4'b0101);

        // Priority clr > set > write
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("clear_all", bus.flags_out, 4'b0000);
        cyc(4'b1111, 4'b1111, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0);
        chk("priority", bus.flags_out, 4'b1110);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("hold", bus.flags_out, 4'b1110);

        // Push saves pre-update flags; pop restores them
        cyc(4'b0000, 4'b0000, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b0);
        chk("set_1010", bus.flags_out, 4'b1010);
        cyc(4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk_state("push1", 4'b0101, 1, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk_state("pop1", 4'b1010, 0, 1'b0, 1'b0);

        // Fill to overflow
        cyc(4'b0001, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc(4'(k + 1), 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
            chk($sformatf("fill%0d_cnt", k), bus.stack_cnt, (k < 4) ? k : 4);
        end
        chk_state("overflow", 4'b0110, 4, 1'b1, 1'b0);
        for (int k = 4; k >= 1; k--) begin
            cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
            chk($sformatf("drain%0d_flags", k), bus.flags_out, 4'(k));
            chk($sformatf("drain%0d_cnt", k), bus.stack_cnt, k - 1);
        end
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk_state("underflow", 4'b0001, 0, 1'b1, 1'b1);

        // err_clr alone, then race against a new overflow
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk_state("err_clr", 4'b0001, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk_state("refill", 4'b0001, 4, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        chk_state("clr_vs_ovf", 4'b0001, 4, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk_state("clr_after", 4'b0001, 4, 1'b0, 1'b0);

        // push & pop together: no stack change, no error, normal update applies
        cyc(4'b1100, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        chk_state("push_pop", 4'b1100, 4, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk_state("pop_after", 4'b0001, 3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
